fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the multi-cycle execute/control unit. It drives the instruction memory address, captures 16-bit instruction words into a small FIFO tagged with their PC, and presents them to the consumer over a valid/ready handshake. It accepts PC redirects (jump/taken beq) from downstream, which flush the queue. It stops prefetching after a halt opcode has been queued.

Parameters:
DEPTH, 4, number of queue entries (power of two, at least 2)
ADDR_W, 8, instruction address width (256-word memory space)
INSTR_W, 16, instruction word width

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_W  address to instruction memory; equals fetch_pc combinationally
imem_data  input  INSTR_W  instruction memory read data; combinational, valid in the same cycle
out_valid  output  1  queue head holds a valid instruction
out_ready  input  1  consumer accepts the head this cycle
out_instr  output  INSTR_W  head instruction word; opcode is in bits [15:12]
out_pc  output  ADDR_W  PC of the head instruction
redirect_valid  input  1  flush the queue and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address
count  output  $clog2(DEPTH+1)  current occupancy
fetch_stopped  output  1  halt opcode (4'hF) has been enqueued; prefetch suspended

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (reset). While reset is asserted: fetch_pc=0, head=tail=0, count=0, out_valid=0, out_instr=0, out_pc=0, fetch_stopped=0.
- pop = out_valid & out_ready.
- push = !fetch_stopped & !redirect_valid & (count<DEPTH | pop). On push, {imem_data, fetch_pc} is written at tail, tail increments, and fetch_pc <= fetch_pc+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00).
- count updates as count + push - pop. Simultaneous push and pop when full is legal and count stays at DEPTH. Pop when empty is impossible because out_valid=0.
- Head/tail pointers wrap modulo DEPTH.
- out_valid = (count!=0). out_instr and out_pc are the head entry read combinationally. Both are 0 when count==0.
- Latency: a word at imem_addr in cycle N appears at the outputs in cycle N+1 if the queue was empty. Throughput is one instruction per cycle.
- Halt: if the word being pushed has imem_data[15:12]==4'hF, the halt itself is enqueued and fetch_stopped <= 1. fetch_pc still increments past it. No further pushes occur until redirect or reset. Already-queued entries still drain normally.
- Redirect (highest priority): on the edge where redirect_valid=1, head=tail=0, count=0, fetch_pc <= redirect_pc, fetch_stopped <= 0. Pop and push are ignored that cycle. Outputs are empty in the next cycle, and the first redirected word is valid one cycle after that.
- Redirect while reset is asserted: reset wins.
- Reset mid-operation clears all state immediately; entries in flight are discarded.
- imem_addr never depends on out_ready, so there is no combinational path from out_ready to imem_addr.

Test Plan:
- Reset, memory words 0..7 = 16'h8121,16'h4234,..., out_ready=1 -> out_valid rises one cycle after reset release; out_pc sequence 0,1,2,... with the matching instruction words, one per cycle.
- out_ready=0 for 10 cycles -> count saturates at 4, imem_addr holds at 4, out_pc holds at 0. Then out_ready=1 -> pops pc 0,1,2,3,4,... with no gap and no duplicates.
- Full queue with out_ready=1 continuously -> count stays 4 and a push and a pop occur every cycle.
- redirect_valid pulse with redirect_pc=8'h30 while holding 3 entries -> next cycle count=0 and out_valid=0; the following cycle out_pc=8'h30 and out_instr=mem[48].
- mem[5]=16'hF000 -> entries for pc 0..5 are queued and fetch_stopped=1. imem_addr holds at 6 and pc 6 is never enqueued. A redirect to 0 clears fetch_stopped.
- Redirect to 8'hFE -> out_pc sequence FE, FF, 00, 01, showing wrap-around. Assert reset mid-stream -> out_valid=0 and count=0 immediately, and imem_addr=0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding the execute/control unit.
// Ports: clk, reset (async, active-high); imem_addr/imem_data to the
//   instruction memory; out_valid/out_ready/out_instr/out_pc handshake
//   to the consumer; redirect_valid/redirect_pc from downstream; count
//   (occupancy) and fetch_stopped (halt queued) status.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       fetch_stopped
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              pop;
    logic              push;
    logic              is_halt;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A full queue can still accept a word when the head leaves this cycle.
    assign push      = !fetch_stopped && !redirect_valid &&
                       ((count < FULL_CNT) || pop);
    assign is_halt   = (imem_data[INSTR_W-1 -: 4] == 4'hF);

    assign out_instr = out_valid ? q_instr[head] : '0;
    assign out_pc    = out_valid ? q_pc[head]    : '0;

    // Storage needs no reset: it is masked by count until written.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_data;
            q_pc[tail]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc      <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            fetch_stopped <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc      <= redirect_pc;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            fetch_stopped <= 1'b0;
        end else begin
            if (push) begin
                tail     <= tail + PTR_W'(1);
                fetch_pc <= fetch_pc + ADDR_W'(1);
                if (is_halt) begin
                    fetch_stopped <= 1'b1;
                end
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test of fetch_queue.
// Drives a behavioural instruction memory and checks handshake outputs.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [2:0]  count;
    logic        fetch_stopped;

    logic [15:0] mem [256];

    int total;
    int bad;

    fetch_queue #(
        .DEPTH(4),
        .ADDR_W(8),
        .INSTR_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .count(count),
        .fetch_stopped(fetch_stopped)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'h2, 8'(i), 4'h5};
        end
        mem[0] = 16'h8121;
        mem[1] = 16'h4234;

        // Reset values
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'd0);
        chk("rst_stop", 32'(fetch_stopped), 32'd0);

        // Streaming with consumer always ready
        out_ready = 1'b1;
        reset = 1'b0;
        chk("t1_valid0", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_pc", 32'(out_pc), 32'(i));
            chk("t1_instr", 32'(out_instr), 32'(mem[i]));
            chk("t1_count", 32'(count), 32'd1);
        end

        // Backpressure fills the queue, then full-rate drain
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_addr", 32'(imem_addr), 32'd4);
        chk("t2_pc", 32'(out_pc), 32'd0);
        chk("t2_instr", 32'(out_instr), 32'h8121);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_pc", 32'(out_pc), 32'(i));
            chk("t3_instr", 32'(out_instr), 32'(mem[i]));
            chk("t3_count", 32'(count), 32'd4);
            chk("t3_addr", 32'(imem_addr), 32'(4 + i));
            step();
        end

        // Redirect while holding three entries
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        chk("t4_count3", 32'(count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc = 8'h30;
        step();
        redirect_valid = 1'b0;
        chk("t4_count0", 32'(count), 32'd0);
        chk("t4_valid0", 32'(out_valid), 32'd0);
        chk("t4_addr", 32'(imem_addr), 32'h30);
        step();
        chk("t4_valid1", 32'(out_valid), 32'd1);
        chk("t4_pc", 32'(out_pc), 32'h30);
        chk("t4_instr", 32'(out_instr), 32'h2305);
        chk("t4_count1", 32'(count), 32'd1);

        // Halt opcode stops prefetch
        mem[5] = 16'hF000;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_pc", 32'(out_pc), 32'(i));
            chk("t5_instr", 32'(out_instr), 32'(mem[i]));
        end
        chk("t5_stop", 32'(fetch_stopped), 32'd1);
        chk("t5_addr", 32'(imem_addr), 32'd6);
        step();
        chk("t5_empty", 32'(out_valid), 32'd0);
        step();
        step();
        step();
        chk("t5_addr_hold", 32'(imem_addr), 32'd6);
        chk("t5_still_empty", 32'(count), 32'd0);
        chk("t5_stop_hold", 32'(fetch_stopped), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        step();
        redirect_valid = 1'b0;
        chk("t5_unstop", 32'(fetch_stopped), 32'd0);
        chk("t5_raddr", 32'(imem_addr), 32'd0);
        step();
        chk("t5_rvalid", 32'(out_valid), 32'd1);
        chk("t5_rpc", 32'(out_pc), 32'd0);
        mem[5] = {4'h2, 8'h05, 4'h5};

        // PC wrap-around and asynchronous reset mid-stream
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect_valid = 1'b0;
        chk("t6_empty", 32'(out_valid), 32'd0);
        step();
        chk("t6_pc_fe", 32'(out_pc), 32'hFE);
        chk("t6_in_fe", 32'(out_instr), 32'h2FE5);
        step();
        chk("t6_pc_ff", 32'(out_pc), 32'hFF);
        step();
        chk("t6_pc_00", 32'(out_pc), 32'h00);
        chk("t6_in_00", 32'(out_instr), 32'h8121);
        step();
        chk("t6_pc_01", 32'(out_pc), 32'h01);
        chk("t6_addr", 32'(imem_addr), 32'h02);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_addr", 32'(imem_addr), 32'd0);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
